// File: rtl/draw_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// draw_scheduler_pkg
// Shared definitions for the sprite draw scheduler: FSM state encoding,
// LCD geometry and the widths of the coordinate / ROM id fields that are
// carried from a requester to the mif-drawing engine.
// -----------------------------------------------------------------------------
package draw_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } sched_state_t;

    localparam int LCD_WIDTH  = 240;
    localparam int LCD_HEIGHT = 320;

    localparam int X_W     = 8;
    localparam int Y_W     = 9;
    localparam int ROMID_W = 4;

endpackage

// File: rtl/draw_scheduler_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector. Starting one position after
// the pointer and wrapping modulo NUM_REQ, it returns the first set request.
//
// Ports:
//   req        in   NUM_REQ  request vector
//   ptr        in   PTR_W    last served requester
//   win_onehot out  NUM_REQ  one-hot winner (all zero when req is zero)
//   win_idx    out  PTR_W    index of the winner (0 when req is zero)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [PTR_W-1:0]   win_idx
);

    logic             found;
    logic [PTR_W-1:0] cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        cand       = '0;
        // Scan ptr+1 .. ptr+NUM_REQ so the last winner has lowest priority.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found            = 1'b1;
                win_onehot[cand] = 1'b1;
                win_idx          = cand;
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// -----------------------------------------------------------------------------
// draw_scheduler
// Arbitrates sprite draw requests from NUM_REQ game-logic requesters onto a
// single mif-drawing engine. The winner's coordinates and ROM id are latched
// for the whole grant, the engine's draw/ready handshake is run, and a
// one-cycle done or timeout pulse is returned to the granted requester.
//
// Ports:
//   clock       in   1           system clock
//   reset       in   1           asynchronous reset, active low
//   req         in   NUM_REQ     level request per requester
//   reqX        in   8*NUM_REQ   packed x origins
//   reqY        in   9*NUM_REQ   packed y origins
//   reqROMId    in   4*NUM_REQ   packed ROM ids
//   grant       out  NUM_REQ     one-hot, held until completion
//   done        out  NUM_REQ     1-cycle pulse, draw finished
//   timeout     out  NUM_REQ     1-cycle pulse, engine never accepted
//   busy        out  1           not idle
//   engXOrigin  out  8           engine x origin
//   engYOrigin  out  9           engine y origin
//   engROMId    out  4           engine ROM id
//   engDraw     out  1           engine draw strobe
//   engReady    in   1           engine ready
// -----------------------------------------------------------------------------
module draw_scheduler
    import draw_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ACCEPT_TIMEOUT = 1024,
    parameter int PTR_W          = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [X_W*NUM_REQ-1:0]       reqX,
    input  logic [Y_W*NUM_REQ-1:0]       reqY,
    input  logic [ROMID_W*NUM_REQ-1:0]   reqROMId,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic [NUM_REQ-1:0]           timeout,
    output logic                         busy,
    output logic [X_W-1:0]               engXOrigin,
    output logic [Y_W-1:0]               engYOrigin,
    output logic [ROMID_W-1:0]           engROMId,
    output logic                         engDraw,
    input  logic                         engReady
);

    localparam int CNT_W = $clog2(ACCEPT_TIMEOUT) + 1;

    // Unpacked views of the per-requester parameter buses.
    logic [X_W-1:0]     x_arr   [NUM_REQ];
    logic [Y_W-1:0]     y_arr   [NUM_REQ];
    logic [ROMID_W-1:0] rom_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign x_arr[i]   = reqX[i*X_W +: X_W];
        assign y_arr[i]   = reqY[i*Y_W +: Y_W];
        assign rom_arr[i] = reqROMId[i*ROMID_W +: ROMID_W];
    end

    sched_state_t         state_q,   state_d;
    logic [PTR_W-1:0]     ptr_q,     ptr_d;
    logic [PTR_W-1:0]     gidx_q,    gidx_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [NUM_REQ-1:0]   grant_q,   grant_d;
    logic [NUM_REQ-1:0]   done_q,    done_d;
    logic [NUM_REQ-1:0]   timeout_q, timeout_d;
    logic                 busy_q,    busy_d;
    logic [X_W-1:0]       eng_x_q,   eng_x_d;
    logic [Y_W-1:0]       eng_y_q,   eng_y_d;
    logic [ROMID_W-1:0]   eng_rom_q, eng_rom_d;
    logic                 eng_draw_q, eng_draw_d;

    logic [NUM_REQ-1:0]   win_onehot;
    logic [PTR_W-1:0]     win_idx;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .req        (req),
        .ptr        (ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        done_d     = '0;
        timeout_d  = '0;
        eng_x_d    = eng_x_q;
        eng_y_d    = eng_y_q;
        eng_rom_d  = eng_rom_q;
        eng_draw_d = eng_draw_q;

        case (state_q)
            ST_IDLE: begin
                // Only grant while the engine is idle and ready.
                if (engReady && (|req)) begin
                    grant_d    = win_onehot;
                    gidx_d     = win_idx;
                    eng_x_d    = x_arr[win_idx];
                    eng_y_d    = y_arr[win_idx];
                    eng_rom_d  = rom_arr[win_idx];
                    eng_draw_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Acceptance (ready dropping) wins over an expiring counter.
                if (!engReady) begin
                    eng_draw_d = 1'b0;
                    state_d    = ST_WAIT_DONE;
                end else if (cnt_q == CNT_W'(ACCEPT_TIMEOUT - 1)) begin
                    eng_draw_d = 1'b0;
                    grant_d    = '0;
                    timeout_d  = grant_q;
                    ptr_d      = gidx_q;
                    state_d    = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                // Draw duration is unbounded; wait for ready to return.
                if (engReady) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    ptr_d   = gidx_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                eng_draw_d = 1'b0;
                grant_d    = '0;
                state_d    = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PTR_W'(NUM_REQ - 1);
            gidx_q     <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            timeout_q  <= '0;
            busy_q     <= 1'b0;
            eng_x_q    <= '0;
            eng_y_q    <= '0;
            eng_rom_q  <= '0;
            eng_draw_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            eng_x_q    <= eng_x_d;
            eng_y_q    <= eng_y_d;
            eng_rom_q  <= eng_rom_d;
            eng_draw_q <= eng_draw_d;
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign busy       = busy_q;
    assign engXOrigin = eng_x_q;
    assign engYOrigin = eng_y_q;
    assign engROMId   = eng_rom_q;
    assign engDraw    = eng_draw_q;

endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;

    localparam int NUM_REQ        = 4;
    localparam int ACCEPT_TIMEOUT = 16;
    localparam int PTR_W          = 2;

    localparam int K_GRANT = 0;
    localparam int K_DONE  = 1;
    localparam int K_TO    = 2;

    typedef struct {
        int         kind;
        logic [3:0] vec;
        logic [7:0] x;
        logic [8:0] y;
        logic [3:0] rom;
    } exp_t;

    logic         clock;
    logic         reset;
    logic [3:0]   req;
    logic [31:0]  reqX;
    logic [35:0]  reqY;
    logic [15:0]  reqROMId;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic [3:0]   timeout;
    logic         busy;
    logic [7:0]   engXOrigin;
    logic [8:0]   engYOrigin;
    logic [3:0]   engROMId;
    logic         engDraw;
    logic         engReady;

    logic [7:0]   x_arr   [NUM_REQ];
    logic [8:0]   y_arr   [NUM_REQ];
    logic [3:0]   rom_arr [NUM_REQ];

    exp_t sb [$];

    int n_tests = 0;
    int n_fail  = 0;

    draw_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .ACCEPT_TIMEOUT (ACCEPT_TIMEOUT),
        .PTR_W          (PTR_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .reqX       (reqX),
        .reqY       (reqY),
        .reqROMId   (reqROMId),
        .grant      (grant),
        .done       (done),
        .timeout    (timeout),
        .busy       (busy),
        .engXOrigin (engXOrigin),
        .engYOrigin (engYOrigin),
        .engROMId   (engROMId),
        .engDraw    (engDraw),
        .engReady   (engReady)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        reqX     = '0;
        reqY     = '0;
        reqROMId = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            reqX[i*8 +: 8]     = x_arr[i];
            reqY[i*9 +: 9]     = y_arr[i];
            reqROMId[i*4 +: 4] = rom_arr[i];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_evt(input int kind, input int idx);
        exp_t e;
        e.kind = kind;
        e.vec  = 4'(1 << idx);
        e.x    = x_arr[idx];
        e.y    = y_arr[idx];
        e.rom  = rom_arr[idx];
        sb.push_back(e);
    endtask

    task automatic set_req(input int idx, input logic [7:0] x, input logic [8:0] y, input logic [3:0] rom);
        x_arr[idx]   = x;
        y_arr[idx]   = y;
        rom_arr[idx] = rom;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cpl(input string tag, input int max_cyc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((done | timeout) == 4'd0 && n < max_cyc);
        check_val(tag, 32'((done | timeout) != 4'd0), 32'd1);
    endtask

    // Engine model: drops ready half a cycle after seeing draw, stays busy
    // for eng_lat cycles, then raises ready. eng_mode 1 forces ready.
    int   eng_mode;
    logic eng_force_val;
    int   eng_lat;
    int   e_cnt;
    logic e_busy;

    always @(negedge clock) begin
        if (eng_mode == 1) begin
            engReady = eng_force_val;
            e_busy   = 1'b0;
        end else if (!reset) begin
            e_busy   = 1'b0;
            engReady = 1'b1;
        end else if (e_busy) begin
            if (e_cnt <= 1) begin
                e_busy   = 1'b0;
                engReady = 1'b1;
            end else begin
                e_cnt--;
            end
        end else if (engDraw) begin
            e_busy   = 1'b1;
            e_cnt    = eng_lat;
            engReady = 1'b0;
        end else begin
            engReady = 1'b1;
        end
    end

    // Output monitor: pops scoreboard entries on grant rise and on pulses.
    logic [3:0] prev_grant = '0;
    logic [3:0] prev_cpl   = '0;
    int         draw_cnt   = 0;
    int         last_draw_len = 0;
    exp_t       me;
    int         obs_kind;

    always @(posedge clock) begin
        #1;
        if (engDraw === 1'b1) begin
            draw_cnt++;
        end else if (draw_cnt != 0) begin
            last_draw_len = draw_cnt;
            draw_cnt      = 0;
        end
        if (grant != 4'd0 && prev_grant == 4'd0) begin
            if (sb.size() == 0) begin
                check_val("sb_underflow_grant", sb.size(), 1);
            end else begin
                me = sb.pop_front();
                obs_kind = K_GRANT;
                check_val("evt_kind", obs_kind, me.kind);
                check_val("grant_vec", grant, me.vec);
                check_val("eng_x", engXOrigin, me.x);
                check_val("eng_y", engYOrigin, me.y);
                check_val("eng_rom", engROMId, me.rom);
                check_val("draw_at_grant", engDraw, 1);
                check_val("busy_at_grant", busy, 1);
            end
        end
        if ((done | timeout) != 4'd0) begin
            check_val("pulse_1cyc", prev_cpl, 0);
            if (sb.size() == 0) begin
                check_val("sb_underflow_cpl", sb.size(), 1);
            end else begin
                me = sb.pop_front();
                obs_kind = (done != 4'd0) ? K_DONE : K_TO;
                check_val("evt_kind", obs_kind, me.kind);
                check_val("cpl_vec", done | timeout, me.vec);
                check_val("draw_at_cpl", engDraw, 0);
            end
        end
        prev_grant = grant;
        prev_cpl   = done | timeout;
    end

    initial begin
        int  n;
        logic reached;
        reset         = 1'b0;
        req           = '0;
        eng_mode      = 1;
        eng_force_val = 1'b0;
        eng_lat       = 5;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'd0, 9'd0, 4'd0);

        // Reset state, with engine not ready and a request already pending.
        set_req(0, 8'd77, 9'd300, 4'd9);
        req = 4'b0001;
        repeat (3) tick();
        check_val("rst_grant", grant, 0);
        check_val("rst_done", done, 0);
        check_val("rst_timeout", timeout, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_draw", engDraw, 0);
        check_val("rst_eng_x", engXOrigin, 0);
        check_val("rst_eng_y", engYOrigin, 0);
        check_val("rst_eng_rom", engROMId, 0);
        reset = 1'b1;

        // Engine not ready: no grant until it becomes ready.
        repeat (5) tick();
        check_val("t5_no_grant", grant, 0);
        check_val("t5_not_busy", busy, 0);
        push_evt(K_GRANT, 0);
        push_evt(K_DONE, 0);
        eng_mode = 0;
        tick();
        check_val("t5_grant_lat", grant, 4'b0001);
        wait_cpl("t5_done_seen", 100);
        req = 4'b0000;

        // Single draw with a long engine busy period.
        tick();
        set_req(0, 8'd10, 9'd20, 4'd3);
        eng_lat = 50;
        push_evt(K_GRANT, 0);
        push_evt(K_DONE, 0);
        req = 4'b0001;
        wait_cpl("t1_done_seen", 200);
        check_val("t1_done_vec", done, 4'b0001);
        req = 4'b0000;
        tick();
        check_val("t1_done_once", done, 0);
        check_val("t1_busy_after", busy, 0);
        check_val("t1_grant_after", grant, 0);
        check_val("t1_draw_len", last_draw_len, 1);

        // Two simultaneous requests straight out of reset.
        reset = 1'b0;
        eng_lat = 5;
        set_req(1, 8'd100, 9'd200, 4'd5);
        set_req(3, 8'd239, 9'd319, 4'd15);
        req = 4'b1010;
        push_evt(K_GRANT, 1);
        push_evt(K_DONE, 1);
        push_evt(K_GRANT, 3);
        push_evt(K_DONE, 3);
        tick();
        tick();
        reset = 1'b1;
        wait_cpl("t2_done1_seen", 100);
        check_val("t2_done1_vec", done, 4'b0010);
        check_val("t2_grant_gap", grant, 0);
        req = 4'b1000;
        tick();
        check_val("t2_grant3", grant, 4'b1000);
        wait_cpl("t2_done3_seen", 100);
        check_val("t2_done3_vec", done, 4'b1000);
        req = 4'b0000;

        // All four requesting continuously for eight draws.
        tick();
        eng_lat = 3;
        set_req(0, 8'd1, 9'd2, 4'd1);
        set_req(1, 8'd3, 9'd4, 4'd2);
        set_req(2, 8'd5, 9'd6, 4'd4);
        set_req(3, 8'd7, 9'd8, 4'd8);
        for (int i = 0; i < 8; i++) begin
            push_evt(K_GRANT, i % 4);
            push_evt(K_DONE, i % 4);
        end
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            wait_cpl("t3_done_seen", 100);
            check_val("t3_done_order", done, 32'(1 << (i % 4)));
        end
        req = 4'b0000;

        // Engine ready stuck high: acceptance times out.
        tick();
        eng_mode      = 1;
        eng_force_val = 1'b1;
        push_evt(K_GRANT, 0);
        push_evt(K_TO, 0);
        push_evt(K_GRANT, 1);
        push_evt(K_TO, 1);
        req = 4'b0011;
        wait_cpl("t4_to0_seen", 60);
        check_val("t4_to0_vec", timeout, 4'b0001);
        check_val("t4_no_done0", done, 0);
        tick();
        req = 4'b0010;
        check_val("t4_draw_len0", last_draw_len, ACCEPT_TIMEOUT);
        check_val("t4_next_grant", grant, 4'b0010);
        wait_cpl("t4_to1_seen", 60);
        check_val("t4_to1_vec", timeout, 4'b0010);
        req = 4'b0000;
        tick();
        check_val("t4_draw_len1", last_draw_len, ACCEPT_TIMEOUT);
        eng_mode = 0;

        // Asynchronous reset while waiting for the engine to finish.
        tick();
        eng_lat = 40;
        set_req(0, 8'd5, 9'd6, 4'd7);
        set_req(1, 8'd8, 9'd9, 4'd10);
        push_evt(K_GRANT, 0);
        req = 4'b0001;
        n = 0;
        reached = 1'b0;
        while (!reached && n < 20) begin
            tick();
            n++;
            if (grant != 4'd0 && engDraw == 1'b0) reached = 1'b1;
        end
        check_val("t6_in_wait_done", reached, 1);
        req = 4'b0011;
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check_val("t6_rst_grant", grant, 0);
        check_val("t6_rst_draw", engDraw, 0);
        check_val("t6_rst_busy", busy, 0);
        push_evt(K_GRANT, 0);
        push_evt(K_DONE, 0);
        push_evt(K_GRANT, 1);
        push_evt(K_DONE, 1);
        eng_lat = 5;
        tick();
        tick();
        reset = 1'b1;
        wait_cpl("t6_done0_seen", 100);
        check_val("t6_done0_vec", done, 4'b0001);
        req = 4'b0010;
        wait_cpl("t6_done1_seen", 100);
        check_val("t6_done1_vec", done, 4'b0010);
        req = 4'b0000;

        tick();
        tick();
        check_val("sb_empty", sb.size(), 0);
        check_val("final_busy", busy, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
